// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder: accepts in IDLE only, answers LATENCY cycles after acceptance.
// Optional DMEM_ALIGN_CHECK_EN rejects non-word-aligned addresses; otherwise addr[1:0] is ignored.
module data_mem_responder #(
  parameter int          WORDS     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_mem [WORDS];
  logic        r_err;
  logic        r_store;
  logic [IW-1:0] r_idx;
  logic [31:0] r_wdata;

  logic [31:0] w_off;
  logic        w_oor;
  logic        w_misalign;
  logic        w_req_err;
  logic        w_accept;
  logic        w_commit;

  // Offset wraps mod 2^32, so addresses below BASE_ADDR land far out of range.
  assign w_off = addr - BASE_ADDR;
  assign w_oor = (w_off >= (32'(WORDS) << 2));
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = (addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_req_err = (MemRead == MemWrite) || w_oor || w_misalign;
  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_commit  = (r_state == S_RESP) && r_store && !r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    resp_err   = (r_state == S_RESP) && r_err;
    rdata      = 32'd0;
    if ((r_state == S_RESP) && !r_err && !r_store) rdata = r_mem[r_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err   <= 1'b0;
      r_store <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_err   <= w_req_err;
      r_store <= MemWrite;
      r_idx   <= w_off[IW+1:2];
      r_wdata <= wdata;
    end
  end

  // Store commits as RESP ends, so a load accepted next already sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) r_mem[i] <= 32'd0;
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against an edge-counting reference model.
module tb_data_mem_responder;
  localparam int          L     = 2;
  localparam int          WORDS = 256;
  localparam logic [31:0] BASE  = 32'h10000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, MemRead, MemWrite;
  logic [31:0] addr, wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] rdata;

  logic        reset1, req_valid1, rd1, wr1;
  logic [31:0] addr1, wdata1;
  logic        ready1, rv1, err1;
  logic [31:0] rdata1;

  data_mem_responder #(.WORDS(WORDS), .LATENCY(L), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .resp_err(resp_err));

  data_mem_responder #(.WORDS(WORDS), .LATENCY(1), .BASE_ADDR(BASE)) u_lat1 (
    .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_ready(ready1),
    .MemRead(rd1), .MemWrite(wr1), .addr(addr1), .wdata(wdata1),
    .resp_valid(rv1), .rdata(rdata1), .resp_err(err1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: edge numbers, one pending request, plain array storage.
  int          e = 0;
  bit          pend = 1'b0;
  int          acc_e = 0;
  bit          m_err, m_store;
  int          m_idx;
  logic [31:0] m_wdata;
  logic [31:0] mem [WORDS];
  int          n_acc = 0;

  function automatic bit req_is_err(input logic rd, input logic wr, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (rd == wr) return 1'b1;
    if ((off >> 2) >= WORDS) return 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    e++;
    if (reset) begin
      foreach (mem[i]) mem[i] = 32'd0;
      pend = 1'b0;
    end else begin
      bit was;
      was = pend;
      if (pend && e == acc_e + L) begin
        if (m_store && !m_err) mem[m_idx] = m_wdata;
        pend = 1'b0;
      end
      if (!was && req_valid) begin
        pend    = 1'b1;
        acc_e   = e;
        n_acc++;
        m_err   = req_is_err(MemRead, MemWrite, addr);
        m_store = MemWrite;
        m_idx   = int'(((addr - BASE) >> 2) & 32'(WORDS - 1));
        m_wdata = wdata;
      end
    end
  end

  logic        exp_resp, exp_err;
  logic [31:0] exp_rdata;
  int          last_e = -1;
  logic [31:0] last_rdata;
  logic        last_err;
  int          n_resp = 0;

  always @(negedge clk) begin
    if (e >= 1) begin
      exp_resp  = pend && (e == acc_e + L - 1);
      exp_err   = exp_resp && m_err;
      exp_rdata = (exp_resp && !m_err && !m_store) ? mem[m_idx] : 32'd0;
      chk("req_ready",  {31'd0, req_ready},  {31'd0, !pend});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp});
      chk("resp_err",   {31'd0, resp_err},   {31'd0, exp_err});
      chk("rdata",      rdata,               exp_rdata);
      if (resp_valid) begin
        last_e     = e;
        last_rdata = rdata;
        last_err   = resp_err;
        n_resp++;
      end
    end
  end

  // One request from idle; returns with the DUT idle again and the response captured.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output int acc);
    @(negedge clk);
    last_e = -1;
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; addr = a; wdata = d;
    @(posedge clk);
    #1 acc = e;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (L + 1) @(negedge clk);
    #1;
  endtask

  initial begin
    int a, n0, r0;
    reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = 32'd0; wdata = 32'd0;
    reset1 = 1'b1; req_valid1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0; reset1 = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // LATENCY=1 instance: store, then back-to-back load of the same word
    req_valid1 = 1'b1; wr1 = 1'b1; addr1 = 32'h10000008; wdata1 = 32'hA5A50001;
    @(negedge clk);
    chk("l1_st_rv", {31'd0, rv1}, 32'd1);
    chk("l1_st_ready", {31'd0, ready1}, 32'd0);
    chk("l1_st_err", {31'd0, err1}, 32'd0);
    chk("l1_st_rdata", rdata1, 32'd0);
    req_valid1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    chk("l1_ready_back", {31'd0, ready1}, 32'd1);
    chk("l1_rv_low", {31'd0, rv1}, 32'd0);
    req_valid1 = 1'b1; rd1 = 1'b1;
    @(negedge clk);
    chk("l1_ld_rv", {31'd0, rv1}, 32'd1);
    chk("l1_ld_rdata", rdata1, 32'hA5A50001);
    req_valid1 = 1'b0; rd1 = 1'b0;
    @(negedge clk);
    chk("l1_ready_back2", {31'd0, ready1}, 32'd1);

    // Store then load
    txn(1'b0, 1'b1, 32'h10000004, 32'hDEADBEEF, a);
    chk("st_rsp_edge", last_e, a + L - 1);
    chk("st_err", {31'd0, last_err}, 32'd0);
    txn(1'b1, 1'b0, 32'h10000004, 32'd0, a);
    chk("ld_rdata", last_rdata, 32'hDEADBEEF);

    // Out-of-range store, then word 0, then dual-op
    txn(1'b0, 1'b1, 32'h10000400, 32'h11111111, a);
    chk("oor_err", {31'd0, last_err}, 32'd1);
    txn(1'b1, 1'b0, 32'h10000000, 32'd0, a);
    chk("w0_rdata", last_rdata, 32'd0);
    txn(1'b1, 1'b1, 32'h10000004, 32'd0, a);
    chk("dual_err", {31'd0, last_err}, 32'd1);

    // req_valid held for 6 edges
    @(negedge clk);
    n0 = n_acc; r0 = n_resp;
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h10000004;
    repeat (6) @(negedge clk);
    req_valid = 1'b0;
    repeat (L + 1) @(negedge clk);
    #1;
    chk("b2b_model_acc", n_acc - n0, 32'd2);
    chk("b2b_dut_resp", n_resp - r0, 32'd2);

    // Reset during BUSY of a store to word 3
    @(negedge clk);
    r0 = n_resp;
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; addr = 32'h1000000C; wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_busy_noresp", n_resp - r0, 32'd0);
    txn(1'b1, 1'b0, 32'h1000000C, 32'd0, a);
    chk("rst_busy_w3", last_rdata, 32'd0);

    // Misaligned load
    txn(1'b0, 1'b1, 32'h10000004, 32'hCAFEF00D, a);
    txn(1'b1, 1'b0, 32'h10000006, 32'd0, a);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("align_err", {31'd0, last_err}, 32'd1);
    chk("align_rdata", last_rdata, 32'd0);
`else
    chk("align_err", {31'd0, last_err}, 32'd0);
    chk("align_rdata", last_rdata, 32'hCAFEF00D);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      reset = ($urandom_range(0, 79) == 0);
      req_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      MemRead  = (r < 4) || (r == 8);
      MemWrite = ((r >= 4) && (r < 8)) || (r == 8);
      r = $urandom_range(0, 9);
      if (r == 0) addr = $urandom;
      else if (r == 1) addr = BASE + 32'h3F8 + 32'($urandom_range(0, 15));
      else addr = BASE + 32'($urandom_range(0, 31) << 2)
                  + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      wdata = $urandom;
    end
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    repeat (L + 3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
